bram_sdp_ctrl: RTL and testbench

Parametrised single-clock simple-dual-port block RAM controller. It is the next-generation replacement for the fixed-geometry primitive wrapper and builds on inferred RAM rather than a single 5K/10K tile. Over the fixed wrapper it adds:
- arbitrary width and depth;
- per-byte write enables;
- selectable read-during-write collision behaviour;
- an optional pipeline output register with a read-valid strobe;
- a post-reset clear engine that initialises every word before user traffic is accepted.

It sits between datapath FIFOs/line buffers and the RAM fabric.

---
 rtl/bram_sdp_ctrl.sv | 135 +++++++++++++
 tb/tb_bram_sdp_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_sdp_ctrl : parametrised simple-dual-port RAM controller with byte     |
// |                 enables, collision mode, optional output register, clear.  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module bram_sdp_ctrl #(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  BYTE_WIDTH     = 8,
    parameter int                  ADDR_WIDTH     = 10,
    parameter string               WRITE_MODE     = "READ_FIRST",
    parameter int                  OUTPUT_REG     = 0,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wbe,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic                               re,
    input  logic [ADDR_WIDTH-1:0]              raddr,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic                               rvalid,
    output logic                               busy
);

    localparam int c_nbytes      = DATA_WIDTH / BYTE_WIDTH;
    localparam int c_depth       = 2 ** ADDR_WIDTH;
    localparam bit c_write_first = (WRITE_MODE == "WRITE_FIRST");

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [c_depth];
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;

    logic                    w_wr_en;
    logic                    w_rd_en;
    logic                    w_collide;
    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_wr_en   = (r_state == ST_RUN) && we && !rst;
    assign w_rd_en   = (r_state == ST_RUN) && re && !rst;
    assign w_collide = w_wr_en && (waddr == raddr);
    assign w_old     = r_mem[raddr];
    assign busy      = (r_state == ST_CLEAR);

    // Merged word only matters on a collision, where raddr's old word is waddr's.
    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < c_nbytes; b++) begin
            if (wbe[b]) begin
                w_merged[b*BYTE_WIDTH +: BYTE_WIDTH] = wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign w_rd_word = (c_write_first && w_collide) ? w_merged : w_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (&r_clr_ptr) begin
                r_state <= ST_RUN;
            end else begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
        end
    end

    // Memory array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_ptr] <= CLEAR_VALUE;
            end else if (w_wr_en) begin
                for (int b = 0; b < c_nbytes; b++) begin
                    if (wbe[b]) begin
                        r_mem[waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_out_data;
            logic                  r_out_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= r_rd_valid;
                    if (r_rd_valid) begin
                        r_out_data <= r_rd_data;
                    end
                end
            end

            assign rdata  = r_out_data;
            assign rvalid = r_out_valid;
        end else begin : g_no_out_reg
            assign rdata  = r_rd_data;
            assign rvalid = r_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bram_sdp_ctrl : two configurations of bram_sdp_ctrl (READ_FIRST/no reg, |
// |                    WRITE_FIRST/out reg) against one behavioural model.     |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_bram_sdp_ctrl;

    localparam int          DW    = 32;
    localparam int          AW    = 10;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] CV    = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [3:0]    wbe;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re;
    logic [AW-1:0] raddr;

    logic [DW-1:0] rdata_rf, rdata_wf;
    logic          rvalid_rf, rvalid_wf, busy_rf, busy_wf;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    bram_sdp_ctrl #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .WRITE_MODE("READ_FIRST"),
        .OUTPUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut_rf (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_rf), .rvalid(rvalid_rf), .busy(busy_rf)
    );

    bram_sdp_ctrl #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .WRITE_MODE("WRITE_FIRST"),
        .OUTPUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut_wf (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_wf), .rvalid(rvalid_wf), .busy(busy_wf)
    );

    // Reference model: word array, remaining clear count, expected outputs.
    logic [31:0] m_mem [DEPTH];
    int          m_clear_left;
    logic        ea_v, eb_v, pb_v;
    logic [31:0] ea_d, eb_d, pb_d;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic        l_v;
        logic [31:0] l_rf, l_wf, old_r, merged;
        l_v  = 1'b0;
        l_rf = '0;
        l_wf = '0;
        if (rst) begin
            m_clear_left = DEPTH;
            ea_v = 0; ea_d = '0; eb_v = 0; eb_d = '0; pb_v = 0; pb_d = '0;
            return;
        end
        if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = CV;
            m_clear_left--;
        end else begin
            merged = m_mem[waddr];
            for (int b = 0; b < 4; b++)
                if (wbe[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
            if (re) begin
                old_r = m_mem[raddr];
                l_v   = 1'b1;
                l_rf  = old_r;
                l_wf  = (we && waddr == raddr) ? merged : old_r;
            end
            if (we) m_mem[waddr] = merged;
        end
        ea_v = l_v;
        if (l_v) ea_d = l_rf;
        eb_v = pb_v;
        if (pb_v) eb_d = pb_d;
        pb_v = l_v;
        pb_d = l_wf;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_eq("busy_rf",   {31'd0, busy_rf},   {31'd0, m_clear_left > 0});
        chk_eq("busy_wf",   {31'd0, busy_wf},   {31'd0, m_clear_left > 0});
        chk_eq("rvalid_rf", {31'd0, rvalid_rf}, {31'd0, ea_v});
        chk_eq("rdata_rf",  rdata_rf, ea_d);
        chk_eq("rvalid_wf", {31'd0, rvalid_wf}, {31'd0, eb_v});
        chk_eq("rdata_wf",  rdata_wf, eb_d);
    endtask

    task automatic idle();
        we = 0; re = 0; wbe = '0; waddr = '0; wdata = '0; raddr = '0;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        we = 1; waddr = AW'(a); wdata = d; wbe = be;
        tick();
        idle();
    endtask

    task automatic do_read(input int a, input logic [31:0] exp_rf, input logic [31:0] exp_wf);
        re = 1; raddr = AW'(a);
        tick();
        chk_eq("read_rf", rdata_rf, exp_rf);
        chk_eq("read_rf_valid", {31'd0, rvalid_rf}, 32'd1);
        idle();
        tick();
        chk_eq("read_wf", rdata_wf, exp_wf);
        chk_eq("read_wf_valid", {31'd0, rvalid_wf}, 32'd1);
    endtask

    task automatic count_clear(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_rf && n < 3000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        idle();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        rst = 0;

        // First clear, with a write and a read injected while busy.
        n = 0;
        do begin
            idle();
            if (n == 9)  begin we = 1; waddr = 3; wdata = '1; wbe = '1; end
            if (n == 11) begin re = 1; raddr = 3; end
            tick();
            n++;
            if (n == 12) chk_eq("drop_rvalid_rf", {31'd0, rvalid_rf}, 32'd0);
            if (n == 13) chk_eq("drop_rvalid_wf", {31'd0, rvalid_wf}, 32'd0);
        end while (busy_rf && n < 3000);
        idle();
        chk_eq("clear_len", n, 32'd1024);

        do_read(0,    CV, CV);
        do_read(511,  CV, CV);
        do_read(1023, CV, CV);
        do_read(3,    CV, CV);

        do_write(5, 32'h11223344, 4'hF);
        do_write(5, 32'hAABBCCDD, 4'b0101);
        do_read(5, 32'h11BB33DD, 32'h11BB33DD);

        do_write(7, 32'h0, 4'hF);
        we = 1; waddr = 7; wdata = 32'hDEADBEEF; wbe = 4'b0011; re = 1; raddr = 7;
        tick();
        chk_eq("collide_rf", rdata_rf, 32'h00000000);
        idle();
        tick();
        chk_eq("collide_wf", rdata_wf, 32'h0000BEEF);
        do_read(7, 32'h0000BEEF, 32'h0000BEEF);

        for (int i = 0; i < 8; i++) do_write(i, 32'(i * 3), 4'hF);
        for (int i = 0; i < 8; i++) begin
            re = 1; raddr = AW'(i);
            tick();
            chk_eq("stream_rf", rdata_rf, 32'(i * 3));
            chk_eq("stream_rf_valid", {31'd0, rvalid_rf}, 32'd1);
            if (i > 0) chk_eq("stream_wf", rdata_wf, 32'((i - 1) * 3));
        end
        idle();
        tick();
        chk_eq("hold_rf", rdata_rf, 32'd21);
        chk_eq("hold_rf_valid", {31'd0, rvalid_rf}, 32'd0);
        chk_eq("last_wf", rdata_wf, 32'd21);
        tick();
        chk_eq("hold_wf", rdata_wf, 32'd21);
        chk_eq("hold_wf_valid", {31'd0, rvalid_wf}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            we    = 1'($urandom);
            re    = 1'($urandom);
            wbe   = 4'($urandom);
            wdata = $urandom;
            waddr = (i % 8 == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            raddr = (i % 8 == 4) ? AW'($urandom) : AW'($urandom_range(0, 15));
            tick();
        end
        idle();

        // Read in flight when reset hits, then a reset partway through the clear.
        re = 1; raddr = 5;
        tick();
        idle();
        rst = 1;
        tick();
        chk_eq("rst_flight_rdata_wf", rdata_wf, 32'd0);
        chk_eq("rst_flight_rvalid_wf", {31'd0, rvalid_wf}, 32'd0);
        rst = 0;
        for (int i = 0; i < 600; i++) tick();
        rst = 1;
        tick();
        chk_eq("rst_mid_rdata_rf", rdata_rf, 32'd0);
        chk_eq("rst_mid_rvalid_rf", {31'd0, rvalid_rf}, 32'd0);
        rst = 0;
        count_clear(n);
        chk_eq("reclear_len", n, 32'd1024);
        do_read(5, CV, CV);
        do_read(1023, CV, CV);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
